// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the CPU writeback-select stage.
package cpu_wb_pkg;

  localparam int unsigned SEXT_W = 64;

  typedef enum logic [2:0] {
    REGIN_ALU  = 3'd0,
    REGIN_MDR  = 3'd1,
    REGIN_OPB  = 3'd2,
    REGIN_MVI  = 3'd3,
    REGIN_MVHI = 3'd4,
    REGIN_PC   = 3'd5
  } reg_in_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_t;

  // Sign-extend ir[dw-1 -: imm_w] to dw bits; result is zero above dw.
  function automatic logic [SEXT_W-1:0] sext_imm(input logic [SEXT_W-1:0] ir,
                                                 input int unsigned       dw,
                                                 input int unsigned       imm_w);
    logic [SEXT_W-1:0] sh;
    logic [SEXT_W-1:0] msk;
    logic [SEXT_W-1:0] dw_msk;
    logic [SEXT_W-1:0] top;
    sh     = ir >> (dw - imm_w);
    msk    = (SEXT_W'(1) << imm_w) - SEXT_W'(1);
    dw_msk = (dw >= SEXT_W) ? '1 : ((SEXT_W'(1) << dw) - SEXT_W'(1));
    top    = ir >> (dw - 1);
    sh     = sh & msk;
    return top[0] ? ((sh | ~msk) & dw_msk) : sh;
  endfunction

endpackage

// File: rtl/cpu_wb_mux.sv
// Combinational writeback data/destination select for the CPU datapath.
module cpu_wb_mux
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned RAW      = 3,
  parameter int unsigned IMM_W    = 8,
  parameter int unsigned RD_LSB   = 5,
  parameter int unsigned LINK_REG = (2 ** RAW) - 1
) (
  input  logic [2:0]     i_reg_in,
  input  logic           i_reg_w_sel,
  input  logic [DW-1:0]  i_alu_out,
  input  logic [DW-1:0]  i_mdr,
  input  logic [DW-1:0]  i_op_a,
  input  logic [DW-1:0]  i_op_b,
  input  logic [DW-1:0]  i_ir,
  input  logic [DW-1:0]  i_pc,
  output logic [RAW-1:0] o_addr_c,
  output logic [DW-1:0]  o_data_c
);

  logic [IMM_W-1:0] w_imm;
  logic [DW-1:0]    w_imm_ext;
  logic             w_unused_opa;

  assign w_imm        = i_ir[DW-1 -: IMM_W];
  assign w_imm_ext    = DW'(sext_imm(SEXT_W'(i_ir), DW, IMM_W));
  // Only the low half of op_a feeds move-high.
  assign w_unused_opa = ^i_op_a;

  always_comb begin
    o_data_c = '0;
    case (i_reg_in)
      REGIN_ALU:  o_data_c = i_alu_out;
      REGIN_MDR:  o_data_c = i_mdr;
      REGIN_OPB:  o_data_c = i_op_b;
      REGIN_MVI:  o_data_c = w_imm_ext;
      REGIN_MVHI: o_data_c = {w_imm, i_op_a[DW-IMM_W-1:0]};
      REGIN_PC:   o_data_c = i_pc;
      default:    o_data_c = '0;
    endcase
  end

  assign o_addr_c = i_reg_w_sel ? RAW'(LINK_REG) : i_ir[RD_LSB +: RAW];

endmodule

// File: rtl/cpu_wb_stage.sv
// Writeback-select stage with a 2-entry elastic buffer toward the register file.
// Optional forwarding ports are enabled by defining WB_FORWARD_EN.
module cpu_wb_stage
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned RAW      = 3,
  parameter int unsigned IMM_W    = 8,
  parameter int unsigned RD_LSB   = 5,
  parameter int unsigned LINK_REG = (2 ** RAW) - 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     reg_in,
  input  logic           reg_w_sel,
  input  logic [DW-1:0]  alu_out,
  input  logic [DW-1:0]  mdr,
  input  logic [DW-1:0]  op_a,
  input  logic [DW-1:0]  op_b,
  input  logic [DW-1:0]  ir,
  input  logic [DW-1:0]  pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RAW-1:0] out_addr,
  output logic [DW-1:0]  out_data,
`ifdef WB_FORWARD_EN
  input  logic [RAW-1:0] fwd_addr,
  output logic           fwd_hit,
  output logic [DW-1:0]  fwd_data,
`endif
  output logic [1:0]     occupancy
);

  wb_state_t      r_state, w_state_nxt;
  logic [RAW-1:0] r_out_addr, w_out_addr_nxt;
  logic [DW-1:0]  r_out_data, w_out_data_nxt;
  logic [RAW-1:0] r_skid_addr, w_skid_addr_nxt;
  logic [DW-1:0]  r_skid_data, w_skid_data_nxt;
  logic           r_in_ready, w_in_ready_nxt;
  logic           r_out_valid, w_out_valid_nxt;
  logic [1:0]     r_occ, w_occ_nxt;
  logic [RAW-1:0] w_sel_addr;
  logic [DW-1:0]  w_sel_data;
  logic           w_accept;
  logic           w_drain;

  cpu_wb_mux #(
    .DW       (DW),
    .RAW      (RAW),
    .IMM_W    (IMM_W),
    .RD_LSB   (RD_LSB),
    .LINK_REG (LINK_REG)
  ) u_mux (
    .i_reg_in    (reg_in),
    .i_reg_w_sel (reg_w_sel),
    .i_alu_out   (alu_out),
    .i_mdr       (mdr),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_ir        (ir),
    .i_pc        (pc),
    .o_addr_c    (w_sel_addr),
    .o_data_c    (w_sel_data)
  );

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_skid_addr <= w_skid_addr_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_occ       <= w_occ_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
    w_skid_addr_nxt = r_skid_addr;
    w_skid_data_nxt = r_skid_data;
    w_in_ready_nxt  = 1'b1;
    w_out_valid_nxt = 1'b0;
    w_occ_nxt       = 2'd0;

    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ONE;
          w_out_addr_nxt = w_sel_addr;
          w_out_data_nxt = w_sel_data;
        end
      end
      ONE: begin
        if (w_accept && !w_drain) begin
          w_state_nxt     = TWO;
          w_skid_addr_nxt = w_sel_addr;
          w_skid_data_nxt = w_sel_data;
        end else if (w_accept) begin
          w_out_addr_nxt = w_sel_addr;
          w_out_data_nxt = w_sel_data;
        end else if (w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_state_nxt     = ONE;
          w_out_addr_nxt  = r_skid_addr;
          w_out_data_nxt  = r_skid_data;
          w_skid_addr_nxt = '0;
          w_skid_data_nxt = '0;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    // Flush drops everything pending, including a same-cycle accept.
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_out_addr_nxt  = r_out_addr;
      w_out_data_nxt  = r_out_data;
      w_skid_addr_nxt = '0;
      w_skid_data_nxt = '0;
    end

    w_in_ready_nxt  = (w_state_nxt != TWO);
    w_out_valid_nxt = (w_state_nxt != EMPTY);
    case (w_state_nxt)
      ONE:     w_occ_nxt = 2'd1;
      TWO:     w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign occupancy = r_occ;

`ifdef WB_FORWARD_EN
  // Youngest matching entry wins: skid is newer than the output register.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if ((r_state == TWO) && (r_skid_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_skid_data;
    end else if ((r_state != EMPTY) && (r_out_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_out_data;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_wb_stage.sv
// Self-checking bench for cpu_wb_stage: directed cases plus randomized traffic against a queue model.
module tb_cpu_wb_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  reg_in;
  logic        reg_w_sel;
  logic [15:0] alu_out, mdr, op_a, op_b, ir, pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_addr;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
`ifdef WB_FORWARD_EN
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  cpu_wb_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reg_in    (reg_in),
    .reg_w_sel (reg_w_sel),
    .alu_out   (alu_out),
    .mdr       (mdr),
    .op_a      (op_a),
    .op_b      (op_b),
    .ir        (ir),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
`ifdef WB_FORWARD_EN
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write request computed straight from the select rules.
  function automatic ent_t model_sel(input logic [2:0] sel, input logic wsel,
                                     input logic [15:0] a, input logic [15:0] m,
                                     input logic [15:0] oa, input logic [15:0] ob,
                                     input logic [15:0] ins, input logic [15:0] p);
    ent_t e;
    logic [7:0] imm;
    imm    = ins[15:8];
    e.addr = wsel ? 3'd7 : ins[7:5];
    case (sel)
      3'd0:    e.data = a;
      3'd1:    e.data = m;
      3'd2:    e.data = ob;
      3'd3:    e.data = {{8{imm[7]}}, imm};
      3'd4:    e.data = {imm, oa[7:0]};
      3'd5:    e.data = p;
      default: e.data = 16'h0000;
    endcase
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model_upd
    bit acc;
    bit drn;
    if (!reset_n) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (drn) q.delete(0);
        if (acc) q.push_back(model_sel(reg_in, reg_w_sel, alu_out, mdr, op_a, op_b, ir, pc));
      end
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en && reset_n) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      if (q.size() > 0) begin
        chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        chk("out_data", 32'(out_data), 32'(q[0].data));
      end
`ifdef WB_FORWARD_EN
      begin
        logic        eh;
        logic [15:0] ed;
        eh = 1'b0;
        ed = 16'h0;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!eh && q[i].addr == fwd_addr) begin
            eh = 1'b1;
            ed = q[i].data;
          end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(eh));
        chk("fwd_data", 32'(fwd_data), 32'(ed));
      end
`endif
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reg_in = 3'd0; reg_w_sel = 1'b0;
    alu_out = '0; mdr = '0; op_a = '0; op_b = '0; ir = '0; pc = '0;
`ifdef WB_FORWARD_EN
    fwd_addr = 3'd0;
`endif
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    cmp_en = 1'b1;

    // Sign-extended immediate, destination from ir.
    ir = 16'h8A40; reg_in = 3'd3; reg_w_sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("mvi_valid", 32'(out_valid), 32'd1);
    chk("mvi_data", 32'(out_data), 32'hFF8A);
    chk("mvi_addr", 32'(out_addr), 32'd2);
    in_valid = 1'b0;
    tick();
    chk("mvi_drained", 32'(out_valid), 32'd0);

    // Move-high, then link write of pc (accept + drain in ONE).
    ir = 16'h1200; op_a = 16'h00CD; reg_in = 3'd4; in_valid = 1'b1;
    tick();
    chk("mvhi_data", 32'(out_data), 32'h12CD);
    reg_in = 3'd5; reg_w_sel = 1'b1; pc = 16'h0040;
    tick();
    chk("link_addr", 32'(out_addr), 32'd7);
    chk("link_data", 32'(out_data), 32'h0040);
    in_valid = 1'b0; reg_w_sel = 1'b0;
    tick();

    // Back-pressure: third request must wait.
    out_ready = 1'b0; reg_in = 3'd0; in_valid = 1'b1; alu_out = 16'd1;
    tick();
    chk("stall_occ1", 32'(occupancy), 32'd1);
    chk("stall_rdy1", 32'(in_ready), 32'd1);
    alu_out = 16'd2;
    tick();
    chk("stall_occ2", 32'(occupancy), 32'd2);
    chk("stall_rdy2", 32'(in_ready), 32'd0);
    alu_out = 16'd3;
    tick();
    chk("stall_occ3", 32'(occupancy), 32'd2);
    chk("stall_head", 32'(out_data), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_second", 32'(out_data), 32'd2);
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Streaming through ONE with accept and drain every cycle.
    in_valid = 1'b1; alu_out = 16'h0100;
    tick();
    for (int i = 0; i < 8; i++) begin
      alu_out = 16'(16'h0101 + i);
      tick();
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_data", 32'(out_data), 32'(16'h0101 + i));
    end
    in_valid = 1'b0;
    tick();

    // Flush from TWO with a concurrent drain.
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 16'h00AA;
    tick();
    alu_out = 16'h00BB;
    tick();
    in_valid = 1'b0;
    chk("flush_pre_occ", 32'(occupancy), 32'd2);
    chk("flush_head", 32'(out_data), 32'h00AA);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    // Fill both entries with r3 writes and leave stalled.
    out_ready = 1'b0; ir = 16'h0060; reg_in = 3'd0; in_valid = 1'b1; alu_out = 16'h0011;
    tick();
    alu_out = 16'h0022;
    tick();
    in_valid = 1'b0;
    chk("fill_occ", 32'(occupancy), 32'd2);
`ifdef WB_FORWARD_EN
    fwd_addr = 3'd3;
    #1;
    chk("fwd_hit3", 32'(fwd_hit), 32'd1);
    chk("fwd_data3", 32'(fwd_data), 32'h0022);
    fwd_addr = 3'd4;
    #1;
    chk("fwd_hit4", 32'(fwd_hit), 32'd0);
    chk("fwd_data4", 32'(fwd_data), 32'h0000);
`endif

    // Asynchronous reset while stalled.
    #1;
    reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_occ", 32'(occupancy), 32'd0);
    chk("areset_ready", 32'(in_ready), 32'd1);
    chk("areset_data", 32'(out_data), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 32) == 0;
      reg_in    = 3'($urandom);
      reg_w_sel = ($urandom % 4) == 0;
      alu_out   = 16'($urandom);
      mdr       = 16'($urandom);
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      ir        = 16'($urandom);
      pc        = 16'($urandom);
`ifdef WB_FORWARD_EN
      fwd_addr  = 3'($urandom);
`endif
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
